// File: rtl/alu_muldiv_seq_pkg.sv
// Shared constants for the multi-cycle MUL/DIVU/REMU sequencer:
// ALU select codes, M-extension op encodings and sequencer state encoding.
package alu_muldiv_seq_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_OR   = 4'b0100;
   localparam logic [3:0] ALU_AND  = 4'b0101;
   localparam logic [3:0] ALU_XOR  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_SRA  = 4'b1010;
   localparam logic [3:0] ALU_SLT  = 4'b1101;
   localparam logic [3:0] ALU_SLTU = 4'b1111;

   localparam logic [1:0] MD_MUL  = 2'b00;
   localparam logic [1:0] MD_DIVU = 2'b01;
   localparam logic [1:0] MD_REMU = 2'b10;
   localparam logic [1:0] MD_RSVD = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative MUL / DIVU / REMU sequencer that borrows the shared execute-stage ALU:
// shift-add multiply (one ADD per step) and restoring divide (one SUB per step).
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_valid,
   output logic            start_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            result_valid,
   input  logic            result_ready,
   output logic [XLEN-1:0] result,
   output logic            div_by_zero,
   output logic            busy,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_select,
   input  logic [XLEN-1:0] alu_out,
   input  logic            alu_carry
);

   logic [1:0]       state;
   logic [1:0]       op_q;
   logic [CNT_W-1:0] cnt;
   // Registers are shared between the two algorithms:
   // part_q = acc / rem, opnd_q = mcand / dvsr, shift_q = mplier / quot.
   logic [XLEN-1:0]  part_q;
   logic [XLEN-1:0]  opnd_q;
   logic [XLEN-1:0]  shift_q;

   logic [XLEN-1:0]  div_sh;
   logic [XLEN-1:0]  acc_next;
   logic [XLEN-1:0]  rem_next;
   logic [XLEN-1:0]  quot_next;
   logic             take;
   logic             last_step;

   assign div_sh    = {part_q[XLEN-2:0], shift_q[XLEN-1]};
   // rem[31] set means the shifted partial remainder is >= 2^32 > dvsr,
   // so the subtract must be taken even though the ALU carry cannot see bit 32.
   assign take      = part_q[XLEN-1] | alu_carry;
   assign acc_next  = shift_q[0] ? alu_out : part_q;
   assign rem_next  = take ? alu_out : div_sh;
   assign quot_next = {shift_q[XLEN-2:0], take};
   assign last_step = (cnt == CNT_W'(XLEN-1));

   assign start_ready  = (state == ST_IDLE);
   assign result_valid = (state == ST_DONE);
   assign busy         = (state == ST_MUL) || (state == ST_DIV);

   always_comb begin
      alu_a      = '0;
      alu_b      = '0;
      alu_select = ALU_ADD;
      case (state)
         ST_MUL: begin
            alu_a = part_q;
            alu_b = opnd_q;
         end
         ST_DIV: begin
            alu_a      = div_sh;
            alu_b      = opnd_q;
            alu_select = ALU_SUB;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         op_q        <= MD_MUL;
         cnt         <= '0;
         part_q      <= '0;
         opnd_q      <= '0;
         shift_q     <= '0;
         result      <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_valid) begin
                  op_q <= op;
                  cnt  <= '0;
                  case (op)
                     MD_MUL: begin
                        part_q  <= '0;
                        opnd_q  <= operand_a;
                        shift_q <= operand_b;
                        state   <= ST_MUL;
                     end
                     MD_DIVU, MD_REMU: begin
                        if (operand_b != '0) begin
                           part_q  <= '0;
                           shift_q <= operand_a;
                           opnd_q  <= operand_b;
                           state   <= ST_DIV;
                        end else begin
                           result      <= (op == MD_DIVU) ? '1 : operand_a;
                           div_by_zero <= 1'b1;
                           state       <= ST_DONE;
                        end
                     end
                     default: begin
                        result      <= '0;
                        div_by_zero <= 1'b0;
                        state       <= ST_DONE;
                     end
                  endcase
               end
            end
            ST_MUL: begin
               part_q  <= acc_next;
               opnd_q  <= opnd_q << 1;
               shift_q <= shift_q >> 1;
               cnt     <= cnt + CNT_W'(1);
               if (last_step) begin
                  result <= acc_next;
                  state  <= ST_DONE;
               end
            end
            ST_DIV: begin
               part_q  <= rem_next;
               shift_q <= quot_next;
               cnt     <= cnt + CNT_W'(1);
               if (last_step) begin
                  result <= (op_q == MD_DIVU) ? quot_next : rem_next;
                  state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (result_ready) begin
                  div_by_zero <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
